// File: rtl/bus_dma_pkg.sv
// Shared types and constants for the single-channel word-copy engine.
package bus_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_TURN,
        WR_REQ,
        WR_TURN,
        DONE,
        ERR
    } state_t;

    localparam logic [3:0]  WSTRB_READ = 4'h0;
    localparam logic [3:0]  WSTRB_WORD = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/Bus.sv
// Shared valid/ready bus between initiators (CPU, DMA) and slaves.
interface Bus;

    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport Master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport Slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );

endinterface

// File: rtl/bus_initiator.sv
// Single-access bus engine: drives one request, forces a turnaround
// cycle after each handshake and aborts accesses that wait too long.
module bus_initiator
    import bus_dma_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        timeout,
    Bus.Master          bus
);

    logic        r_turn;
    logic [15:0] r_wait;
    logic        w_valid;
    logic        w_timeout;

    always_comb begin
        w_valid   = req && !r_turn;
        bus.valid = w_valid;
        bus.addr  = w_valid ? addr : '0;
        bus.wdata = (w_valid && we) ? wdata : '0;
        bus.wstrb = (w_valid && we) ? WSTRB_WORD : WSTRB_READ;
        ack       = w_valid && bus.ready;
        rdata     = bus.rdata;
        // Fires on the last permitted waiting cycle so valid is high
        // for exactly TIMEOUT cycles before the sequencer aborts.
        w_timeout = (TIMEOUT != 0) && w_valid && !bus.ready
                    && (r_wait == 16'(TIMEOUT - 1));
        timeout   = w_timeout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_turn <= 1'b0;
            r_wait <= '0;
        end else begin
            r_turn <= ack;
            if (w_valid && !bus.ready && !w_timeout)
                r_wait <= r_wait + 16'd1;
            else
                r_wait <= '0;
        end
    end

endmodule

// File: rtl/bus_dma.sv
// Word-copy sequencer: reads src, writes dst, ascending, one word at a time,
// reporting completion or bus timeout through busy/done/error.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    Bus.Master               bus
);

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_data;
    logic [LEN_W-1:0] r_count;
    logic             r_error;

    logic             w_req;
    logic             w_we;
    logic [31:0]      w_addr;
    logic             w_ack;
    logic [31:0]      w_rdata;
    logic             w_timeout;
    logic             w_accept;

    bus_initiator #(
        .TIMEOUT (TIMEOUT)
    ) u_init (
        .clk     (clk),
        .reset   (reset),
        .req     (w_req),
        .we      (w_we),
        .addr    (w_addr),
        .wdata   (r_data),
        .ack     (w_ack),
        .rdata   (w_rdata),
        .timeout (w_timeout),
        .bus     (bus)
    );

    assign w_accept = (r_state == IDLE) && start;
    assign error    = r_error;

    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        w_we   = 1'b0;
        w_addr = r_src;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start)
                    w_next = (len == '0) ? DONE : RD_REQ;
            end
            RD_REQ: begin
                busy  = 1'b1;
                w_req = 1'b1;
                if (w_timeout)
                    w_next = ERR;
                else if (w_ack)
                    w_next = RD_TURN;
            end
            RD_TURN: begin
                busy   = 1'b1;
                w_next = WR_REQ;
            end
            WR_REQ: begin
                busy   = 1'b1;
                w_req  = 1'b1;
                w_we   = 1'b1;
                w_addr = r_dst;
                if (w_timeout)
                    w_next = ERR;
                else if (w_ack)
                    w_next = WR_TURN;
            end
            WR_TURN: begin
                busy   = 1'b1;
                w_next = (r_count == LEN_W'(1)) ? DONE : RD_REQ;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            ERR: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_src   <= src_addr & 32'hFFFF_FFFC;
                r_dst   <= dst_addr & 32'hFFFF_FFFC;
                r_count <= len;
                r_error <= 1'b0;
            end
            if (r_state == RD_REQ && w_ack)
                r_data <= w_rdata;
            // Addresses wrap modulo 2^32 by construction.
            if (r_state == WR_TURN) begin
                r_src   <= r_src + WORD_BYTES;
                r_dst   <= r_dst + WORD_BYTES;
                r_count <= r_count - LEN_W'(1);
            end
            if (w_next == ERR)
                r_error <= 1'b1;
        end
    end

endmodule
